rob_multiport: RTL

// - Parametrised reorder buffer for the out-of-order core: in-order allocation at decode, out-of-order writeback from NUM_WB units.
// - Retires up to COMMIT_WIDTH instructions per cycle in program order, to the RF/RF-ROB and the store buffer.
// - Keeps per-entry exception state, so precise exceptions are raised for the oldest faulting instruction only.
// - Optional partial flush supports branch-mispredict rollback.

---
 rtl/rob_multiport.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: in-order allocate, out-of-order writeback, in-order multi-slot commit.
// Optional partial flush for mispredict rollback is enabled by defining ROB_PARTIAL_FLUSH_EN.
module rob_multiport #(
    parameter int N            = 8,
    parameter int WORD_SIZE    = 32,
    parameter int REG_IDX      = 5,
    parameter int NUM_WB       = 3,
    parameter int COMMIT_WIDTH = 2,
    parameter int CAUSE_W      = 4,
    localparam int IDX         = $clog2(N)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alloc_req,
    input  logic                            alloc_is_store,
    input  logic [REG_IDX-1:0]              alloc_rd,
    input  logic                            alloc_exc,
    input  logic [WORD_SIZE-1:0]            alloc_pc,
    output logic [IDX-1:0]                  alloc_id,
    output logic                            alloc_ok,
    output logic                            full,
    output logic                            empty,
    input  logic [NUM_WB-1:0]               wb_valid,
    input  logic [NUM_WB*IDX-1:0]           wb_id,
    input  logic [NUM_WB*WORD_SIZE-1:0]     wb_value,
    input  logic [NUM_WB-1:0]               wb_exc,
    input  logic [NUM_WB*CAUSE_W-1:0]       wb_cause,
    input  logic [NUM_WB*WORD_SIZE-1:0]     wb_addr,
    input  logic [2*IDX-1:0]                byp_id,
    output logic [1:0]                      byp_valid,
    output logic [2*WORD_SIZE-1:0]          byp_value,
    output logic [COMMIT_WIDTH-1:0]         commit_valid,
    output logic [COMMIT_WIDTH*IDX-1:0]     commit_id,
    output logic [COMMIT_WIDTH*REG_IDX-1:0] commit_rd,
    output logic [COMMIT_WIDTH*WORD_SIZE-1:0] commit_value,
    output logic [COMMIT_WIDTH-1:0]         commit_is_store,
    output logic                            exception,
    output logic [WORD_SIZE-1:0]            ex_pc,
    output logic [WORD_SIZE-1:0]            ex_addr,
    output logic [CAUSE_W-1:0]              ex_cause
`ifdef ROB_PARTIAL_FLUSH_EN
    ,
    input  logic                            flush_valid,
    input  logic [IDX-1:0]                  flush_id
`endif
);

    localparam logic [IDX:0] FULL_CNT = (IDX+1)'(N);
    localparam logic [IDX:0] ONE_CNT  = (IDX+1)'(1);

    logic [N-1:0]         valid_q, valid_d, ready_q, ready_d;
    logic [N-1:0]         store_q, store_d, exc_q, exc_d;
    logic [REG_IDX-1:0]   rd_q    [N];
    logic [REG_IDX-1:0]   rd_d    [N];
    logic [WORD_SIZE-1:0] value_q [N];
    logic [WORD_SIZE-1:0] value_d [N];
    logic [WORD_SIZE-1:0] pc_q    [N];
    logic [WORD_SIZE-1:0] pc_d    [N];
    logic [WORD_SIZE-1:0] addr_q  [N];
    logic [WORD_SIZE-1:0] addr_d  [N];
    logic [CAUSE_W-1:0]   cause_q [N];
    logic [CAUSE_W-1:0]   cause_d [N];
    logic [IDX-1:0]       head_q, head_d, tail_q, tail_d;
    logic [IDX:0]         count_q, count_d;

    logic [IDX-1:0]       slotIdx [COMMIT_WIDTH];
    logic [IDX:0]         retireCnt;
    logic                 retireChain;

    function automatic logic [IDX-1:0] age(input logic [IDX-1:0] idx, input logic [IDX-1:0] base);
        return idx - base;
    endfunction

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign alloc_id  = tail_q;
`ifdef ROB_PARTIAL_FLUSH_EN
    assign alloc_ok  = alloc_req && !full && !flush_valid;
`else
    assign alloc_ok  = alloc_req && !full;
`endif

    assign exception = valid_q[head_q] && ready_q[head_q] && exc_q[head_q];
    assign ex_pc     = pc_q[head_q];
    assign ex_addr   = addr_q[head_q];
    assign ex_cause  = cause_q[head_q];

    // A store at the head retires alone, so younger slots are blocked behind it too.
    always_comb begin
        commit_valid    = '0;
        commit_id       = '0;
        commit_rd       = '0;
        commit_value    = '0;
        commit_is_store = '0;
        retireCnt       = '0;
        retireChain     = !exception;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            slotIdx[k] = head_q + IDX'(k);
            retireChain = retireChain && valid_q[slotIdx[k]] && ready_q[slotIdx[k]]
                          && !exc_q[slotIdx[k]]
                          && ((k == 0) || (!store_q[slotIdx[k]] && !store_q[head_q]));
            commit_valid[k]                         = retireChain;
            commit_id[k*IDX +: IDX]                 = slotIdx[k];
            commit_rd[k*REG_IDX +: REG_IDX]         = rd_q[slotIdx[k]];
            commit_value[k*WORD_SIZE +: WORD_SIZE]  = value_q[slotIdx[k]];
            commit_is_store[k]                      = store_q[slotIdx[k]];
            if (retireChain) begin
                retireCnt = retireCnt + ONE_CNT;
            end
        end
    end

    always_comb begin
        byp_valid = '0;
        byp_value = '0;
        for (int r = 0; r < 2; r++) begin
            byp_valid[r] = valid_q[byp_id[r*IDX +: IDX]] && ready_q[byp_id[r*IDX +: IDX]];
            byp_value[r*WORD_SIZE +: WORD_SIZE] = value_q[byp_id[r*IDX +: IDX]];
        end
    end

    // Later writeback ports overwrite earlier ones, giving the highest port priority.
    always_comb begin : nextState
        logic [IDX-1:0] wbIdx;
        wbIdx   = '0;
        valid_d = valid_q;
        ready_d = ready_q;
        store_d = store_q;
        exc_d   = exc_q;
        rd_d    = rd_q;
        value_d = value_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        cause_d = cause_q;
        head_d  = head_q + retireCnt[IDX-1:0];
        tail_d  = tail_q;
        count_d = count_q + {{IDX{1'b0}}, alloc_ok} - retireCnt;

        if (alloc_ok) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = alloc_exc;
            store_d[tail_q] = alloc_is_store;
            exc_d[tail_q]   = alloc_exc;
            rd_d[tail_q]    = alloc_rd;
            value_d[tail_q] = '0;
            pc_d[tail_q]    = alloc_pc;
            addr_d[tail_q]  = '0;
            cause_d[tail_q] = '0;
            tail_d          = tail_q + IDX'(1);
        end

        for (int p = 0; p < NUM_WB; p++) begin
            wbIdx = wb_id[p*IDX +: IDX];
            if (wb_valid[p] && valid_q[wbIdx]) begin
                ready_d[wbIdx] = 1'b1;
                exc_d[wbIdx]   = wb_exc[p];
                value_d[wbIdx] = wb_value[p*WORD_SIZE +: WORD_SIZE];
                addr_d[wbIdx]  = wb_addr[p*WORD_SIZE +: WORD_SIZE];
                cause_d[wbIdx] = wb_cause[p*CAUSE_W +: CAUSE_W];
            end
        end

        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_valid[k]) begin
                valid_d[slotIdx[k]] = 1'b0;
                ready_d[slotIdx[k]] = 1'b0;
            end
        end

`ifdef ROB_PARTIAL_FLUSH_EN
        if (flush_valid) begin
            for (int i = 0; i < N; i++) begin
                if (age(IDX'(i), head_q) > age(flush_id, head_q)) begin
                    valid_d[i] = 1'b0;
                    ready_d[i] = 1'b0;
                end
            end
            tail_d  = flush_id + IDX'(1);
            count_d = {1'b0, age(flush_id, head_q)} + ONE_CNT - retireCnt;
        end
`endif
    end

    // A fault at the head empties the ROB just like reset, discarding any same-cycle allocation.
    always_ff @(posedge clk) begin
        if (rst || exception) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        store_q <= store_d;
        exc_q   <= exc_d;
        rd_q    <= rd_d;
        value_q <= value_d;
        pc_q    <= pc_d;
        addr_q  <= addr_d;
        cause_q <= cause_d;
    end

endmodule
